// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, aligns/extends load data, selects write-back value.
// Optional misaligned-load fault output enabled by defining MEM_ADEL_CHECK_EN.
module mem_stage #(
    parameter int STALL_WD     = 6,
    parameter int EX_TO_MEM_WD = 147,
    parameter int MEM_TO_WB_WD = 136
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_WB_WD-1:0] mem_to_id_forwarding
`ifdef MEM_ADEL_CHECK_EN
    ,
    output logic                    mem_adel
`endif
);

    logic [EX_TO_MEM_WD-1:0] bus_reg;
    logic                    fresh_reg;
    logic [31:0]             hold_reg;

    logic stop_mem;
    logic stop_wb;
    assign stop_mem = stall[3];
    assign stop_wb  = stall[4];

    // A bubble counts as a new entry too, so fresh rises on both load and bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_reg   <= '0;
            fresh_reg <= 1'b0;
            hold_reg  <= '0;
        end else begin
            if (fresh_reg) begin
                hold_reg <= data_sram_rdata;
            end
            if (stop_mem && !stop_wb) begin
                bus_reg   <= '0;
                fresh_reg <= 1'b1;
            end else if (!stop_mem) begin
                bus_reg   <= ex_to_mem_bus;
                fresh_reg <= 1'b1;
            end else begin
                fresh_reg <= 1'b0;
            end
        end
    end

    logic [4:0]  op_load;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_result;
    logic [31:0] lo_result;
    logic [31:0] pc;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign op_load    = bus_reg[146:142];
    assign hi_we      = bus_reg[141];
    assign lo_we      = bus_reg[140];
    assign hi_result  = bus_reg[139:108];
    assign lo_result  = bus_reg[107:76];
    assign pc         = bus_reg[75:44];
    assign sel_rf_res = bus_reg[38];
    assign rf_we      = bus_reg[37];
    assign rf_waddr   = bus_reg[36:32];
    assign ex_result  = bus_reg[31:0];

    // Store controls and foreign stall bits are not consumed by this stage.
    logic unused_bits;
    assign unused_bits = ^{bus_reg[43:39], stall[STALL_WD-1:5], stall[2:0]};

    logic [31:0] rd;
    logic [1:0]  off;
    assign rd  = fresh_reg ? data_sram_rdata : hold_reg;
    assign off = ex_result[1:0];

    logic [7:0] rd_byte [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign rd_byte[gi] = rd[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    assign byte_sel = rd_byte[off];
    assign half_sel = off[1] ? rd[31:16] : rd[15:0];

    logic [31:0] load_result;
    always_comb begin
        load_result = '0;
        case (op_load)
            5'b00001: load_result = rd;
            5'b00010: load_result = {{24{byte_sel[7]}}, byte_sel};
            5'b00100: load_result = {24'b0, byte_sel};
            5'b01000: load_result = {{16{half_sel[15]}}, half_sel};
            5'b10000: load_result = {16'b0, half_sel};
            default:  load_result = '0;
        endcase
    end

    logic [31:0] rf_wdata;
    logic        rf_we_out;
    assign rf_wdata = sel_rf_res ? load_result : ex_result;

`ifdef MEM_ADEL_CHECK_EN
    logic adel;
    assign adel      = (op_load[0] && (off != 2'b00)) ||
                       ((op_load[3] || op_load[4]) && off[0]);
    assign mem_adel  = adel;
    assign rf_we_out = rf_we && !adel;
`else
    assign rf_we_out = rf_we;
`endif

    assign mem_to_wb_bus = {hi_we, lo_we, hi_result, lo_result, pc,
                            rf_we_out, rf_waddr, rf_wdata};
    assign mem_to_id_forwarding = mem_to_wb_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a field-level reference model.
// Define MEM_ADEL_CHECK_EN to also exercise the misaligned-load fault output.
module tb_mem_stage;

    typedef struct packed {
        logic [4:0]  op;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        en;
        logic [3:0]  wen;
        logic        sel;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] exr;
    } instr_t;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [146:0] bus_in;
    logic [31:0]  rdata;
    logic [135:0] wb;
    logic [135:0] fwd;
`ifdef MEM_ADEL_CHECK_EN
    logic         mem_adel;
`endif

    mem_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .ex_to_mem_bus        (bus_in),
        .data_sram_rdata      (rdata),
        .mem_to_wb_bus        (wb),
        .mem_to_id_forwarding (fwd)
`ifdef MEM_ADEL_CHECK_EN
        ,
        .mem_adel             (mem_adel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: instruction currently in the stage and the data word it saw.
    instr_t      cur;
    logic        first;
    logic [31:0] cur_rd;
    logic        model_valid = 1'b0;

    task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_adel(input instr_t i);
        int off;
        off = int'(i.exr[1:0]);
        if (i.op == 5'b00001) return off != 0;
        if (i.op == 5'b01000 || i.op == 5'b10000) return (off % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input instr_t i, input logic [31:0] rd);
        int off;
        logic [31:0] v;
        off = int'(i.exr[1:0]);
        v = 32'h0;
        case (i.op)
            5'b00001: v = rd;
            5'b00010, 5'b00100: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (i.op == 5'b00010 && v >= 32'd128) v = v - 32'd256;
            end
            5'b01000, 5'b10000: begin
                v = (off >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
                if (i.op == 5'b01000 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic logic [135:0] expect_out(input instr_t i, input logic [31:0] rd);
        logic [31:0] wd;
        logic        we;
        wd = i.sel ? load_val(i, rd) : i.exr;
        we = i.we;
`ifdef MEM_ADEL_CHECK_EN
        if (exp_adel(i)) we = 1'b0;
`endif
        return {i.hi_we, i.lo_we, i.hi, i.lo, i.pc, we, i.waddr, wd};
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int k;
        k = int'($urandom_range(0, 5));
        t.op    = (k == 0) ? 5'b0 : 5'(1 << (k - 1));
        t.hi_we = 1'($urandom);
        t.lo_we = 1'($urandom);
        t.hi    = $urandom;
        t.lo    = $urandom;
        t.pc    = $urandom;
        t.en    = 1'($urandom);
        t.wen   = 4'($urandom);
        t.sel   = (t.op != 5'b0) ? 1'($urandom) : 1'b0;
        t.we    = 1'($urandom);
        t.waddr = 5'($urandom);
        t.exr   = $urandom;
        return t;
    endfunction

    function automatic instr_t mk(input logic [4:0] op, input logic [31:0] exr, input logic sel);
        instr_t t;
        t = rand_instr();
        t.op  = op;
        t.exr = exr;
        t.sel = sel;
        return t;
    endfunction

    // Present one cycle of inputs and check the outputs mid-cycle.
    task automatic drive(input logic r, input logic [5:0] s, input instr_t ins, input logic [31:0] rd);
        logic [135:0] exp;
        rst    = r;
        stall  = s;
        bus_in = ins;
        rdata  = rd;
        #3;
        if (model_valid) begin
            exp = expect_out(cur, first ? rd : cur_rd);
            check_val("wb_bus", wb, exp);
            check_val("fwd_bus", fwd, exp);
`ifdef MEM_ADEL_CHECK_EN
            check_val("adel", 136'(mem_adel), 136'(exp_adel(cur)));
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            cur         = '0;
            first       = 1'b0;
            cur_rd      = 32'h0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (first) cur_rd = rdata;
            if (!stall[3]) begin
                cur   = instr_t'(bus_in);
                first = 1'b1;
            end else if (!stall[4]) begin
                cur   = '0;
                first = 1'b1;
            end else begin
                first = 1'b0;
            end
        end
        #1;
    endtask

    instr_t t;

    initial begin
        rst    = 1'b1;
        stall  = 6'h0;
        bus_in = '0;
        rdata  = 32'h0;
        @(posedge clk);
        #1;

        // Reset held two cycles with random bus content
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 6'($urandom), rand_instr(), $urandom);
            tick();
        end
        drive(1'b0, 6'h0, rand_instr(), $urandom);
        check_val("reset_zero", wb, 136'h0);
        tick();

        // lb sign extension
        t = mk(5'b00010, 32'h1003, 1'b1);
        t.we = 1'b1;
        t.waddr = 5'd5;
        drive(1'b0, 6'h0, t, $urandom);
        tick();
        drive(1'b0, 6'h0, mk(5'b0, $urandom, 1'b0), 32'h80FF_1234);
        check_val("lb_wdata", 136'(wb[31:0]), 136'(32'hFFFF_FF80));
        check_val("lb_waddr", 136'(wb[36:32]), 136'(5'd5));
        check_val("lb_we", 136'(wb[37]), 136'(1'b1));
        // lhu then lh at offset 2; the previous drive loaded lhu's successor slot
        t = mk(5'b10000, 32'h2002, 1'b1);
        bus_in = t;
        tick();
        drive(1'b0, 6'h0, mk(5'b01000, 32'h2002, 1'b1), 32'hBEEF_0001);
        check_val("lhu_wdata", 136'(wb[31:0]), 136'(32'h0000_BEEF));
        tick();
        drive(1'b0, 6'h0, mk(5'b00001, 32'h3000, 1'b1), 32'hBEEF_0001);
        check_val("lh_wdata", 136'(wb[31:0]), 136'(32'hFFFF_BEEF));
        tick();

        // lw held across a 3-cycle freeze while SRAM data changes
        drive(1'b0, 6'b011000, rand_instr(), 32'hDEAD_BEEF);
        check_val("hold_wdata", 136'(wb[31:0]), 136'(32'hDEAD_BEEF));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'b011000, rand_instr(), 32'h0);
            check_val("hold_wdata", 136'(wb[31:0]), 136'(32'hDEAD_BEEF));
            tick();
        end

        // Bubble
        drive(1'b0, 6'b001000, rand_instr(), $urandom);
        tick();
        drive(1'b0, 6'h0, rand_instr(), $urandom);
        check_val("bubble_zero", wb, 136'h0);

        // Non-load pass-through
        t = mk(5'b0, 32'h1234_5678, 1'b0);
        t.hi_we = 1'b1;
        t.hi = 32'hA;
        bus_in = t;
        tick();
        drive(1'b0, 6'h0, rand_instr(), $urandom);
        check_val("pass_wdata", 136'(wb[31:0]), 136'(32'h1234_5678));
        check_val("pass_hi_we", 136'(wb[135]), 136'(1'b1));
        check_val("pass_hi", 136'(wb[133:102]), 136'(32'hA));
        tick();

`ifdef MEM_ADEL_CHECK_EN
        t = mk(5'b00001, 32'h4001, 1'b1);
        t.we = 1'b1;
        drive(1'b0, 6'h0, t, $urandom);
        tick();
        t = mk(5'b01000, 32'h4002, 1'b1);
        t.we = 1'b1;
        drive(1'b0, 6'h0, t, $urandom);
        check_val("adel_lw", 136'(mem_adel), 136'(1'b1));
        check_val("adel_lw_we", 136'(wb[37]), 136'(1'b0));
        tick();
        drive(1'b0, 6'h0, rand_instr(), $urandom);
        check_val("adel_lh", 136'(mem_adel), 136'(1'b0));
        check_val("adel_lh_we", 136'(wb[37]), 136'(1'b1));
        tick();
`endif

        // Randomized traffic with random stalls and occasional reset
        for (int n = 0; n < 600; n++) begin
            logic [5:0] s;
            s = 6'($urandom);
            s[3] = ($urandom_range(0, 99) < 35);
            s[4] = ($urandom_range(0, 99) < 50);
            drive(($urandom_range(0, 99) < 2), s, rand_instr(), $urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
